rvc_asap_dmem_arbiter: RTL and testbench
========================================

Name: rvc_asap_dmem_arbiter

Overview:
Arbitrates the single D_MEM port of the memory wrap between the 5-stage core (Q103H request, Q104H read data) and an external requester such as a program loader or debug/DMA engine.
- Core has default priority.
- A starvation counter guarantees the external side a slot, stalling the core for one cycle when needed.
- Read data returns one cycle after the access and is routed back to whichever side issued it.
- Sits between rvc_asap_5pl's D_MEM outputs and rvc_asap_5pl_mem_wrap's D_MEM inputs.

Parameters:
STARVE_LIMIT, 4, consecutive denied external-request cycles before a forced external grant (legal range 1..255).
CNT_W, 8, starvation counter width; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
Clock  in  1  core clock, rising edge
RstN  in  1  asynchronous active-low reset
CoreAddr  in  32  core D_MEM address (AluOut, Q103H)
CoreWrData  in  32  core write data (RegRdData2, Q103H)
CoreByteEn  in  4  core byte enables
CoreWrEn  in  1  core write request
CoreRdEn  in  1  core read request (SelDMemWb, Q103H)
CoreRdData  out  32  read data to core, Q104H
CoreStall  out  1  core must hold its Q103H request this cycle
ExtReq  in  1  external request valid
ExtWrEn  in  1  external request is a write (else read)
ExtAddr  in  32  external address
ExtWrData  in  32  external write data
ExtByteEn  in  4  external byte enables
ExtGnt  out  1  external request accepted this cycle
ExtRdValid  out  1  ExtRdData valid
ExtRdData  out  32  external read data
MemAddr  out  32  to D_MEM
MemWrData  out  32  to D_MEM
MemByteEn  out  4  to D_MEM
MemWrEn  out  1  to D_MEM
MemRdEn  out  1  to D_MEM
MemRdData  in  32  from D_MEM, valid one cycle after MemRdEn

Behaviour:
- Clock is Clock; reset is RstN, asynchronous, active-low.
- While RstN=0: MemWrEn=0, MemRdEn=0, ExtGnt=0, CoreStall=0, ExtRdValid=0, StarveCnt=0, RdOwnerQ=OWN_NONE.
- CoreAcc = CoreWrEn | CoreRdEn. Force = ExtReq & (StarveCnt >= STARVE_LIMIT).
- Ownership per cycle is combinational, evaluated in this priority order:
  - Force: owner EXT; CoreStall = CoreAcc.
  - CoreAcc: owner CORE; ExtGnt=0.
  - ExtReq: owner EXT; ExtGnt=1.
  - Otherwise: owner NONE; all Mem enables 0.
- Mem outputs are muxed from the owning side.
  - EXT owner: MemWrEn=ExtWrEn, MemRdEn=~ExtWrEn.
  - NONE owner: MemAddr/MemWrData/MemByteEn = core values, enables 0.
- ExtGnt = (owner==EXT). An external transfer completes on ExtReq & ExtGnt. The requester holds all Ext* inputs stable until granted.
- CoreStall: the core holds its Q103H request unchanged while stalled and re-presents it the next cycle. It is never stalled two consecutive cycles, because the forced grant clears StarveCnt.
- StarveCnt:
  - clears on ExtGnt.
  - increments (saturating at 2^CNT_W-1) on ExtReq & ~ExtGnt.
  - holds when ExtReq=0.
- RdOwnerQ, the read-return FSM, has states NONE, CORE, EXT and is registered each cycle:
  - CORE if the core was granted a read.
  - EXT if the external side was granted a read.
  - NONE otherwise, including writes.
- Read return, one cycle latency:
  - ExtRdValid = (RdOwnerQ==EXT); ExtRdData = MemRdData.
  - CoreRdData = MemRdData when RdOwnerQ==CORE, else 0.
- Back-to-back accesses from either side are allowed every cycle. A read followed by a write from the other side needs no bubble.
- Reset mid-read: the pending return is dropped; ExtRdValid never asserts for it.
- STARVE_LIMIT=1: the external side wins every second cycle under continuous contention.

Decomposition:
- rvc_asap_pkg gains typedef enum logic [1:0] t_dmem_owner {OWN_NONE, OWN_CORE, OWN_EXT}.
- rvc_asap_pkg gains a localparam default for DMEM_STARVE_LIMIT.
- One natural sub-module: rvc_asap_starve_cnt, a saturating clear/increment counter with a compare output for Force.

Test Plan:
- Reset: RstN=0 with ExtReq=1, CoreRdEn=1 -> MemRdEn=0, ExtGnt=0, ExtRdValid=0. After release, first cycle: MemRdEn=1, MemAddr=CoreAddr.
- Idle core, ExtReq read addr 0x0000_1000, mem returns 0xDEAD_BEEF -> ExtGnt=1 in cycle 0; ExtRdValid=1 with 0xDEAD_BEEF in cycle 1; CoreRdData=0.
- Core reads every cycle, ExtReq held, STARVE_LIMIT=4 -> ExtGnt=0 for 4 cycles. Cycle 5: ExtGnt=1, CoreStall=1. Cycle 6: core resumes and StarveCnt=0.
- Core read 0x2000 in cycle N, external read 0x3000 in cycle N+1 -> CoreRdData valid in N+1, ExtRdValid=1 in N+2, each with the correct word.
- External write 0x4000 data 0x1234_5678 ByteEn=4'b0011 -> single cycle with MemWrEn=1, MemByteEn=0011; RdOwnerQ=NONE; no ExtRdValid.
- External read granted, RstN pulsed low in the return cycle -> ExtRdValid stays 0; StarveCnt=0 after release.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// rtl/rvc_asap_pkg.sv - shared types and defaults for the rvc_asap core slice
package rvc_asap_pkg;

    localparam int DMEM_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } t_dmem_owner;

endpackage

// File: rtl/rvc_asap_starve_cnt.sv
// rtl/rvc_asap_starve_cnt.sv - saturating starvation counter with limit compare
module rvc_asap_starve_cnt
    import rvc_asap_pkg::*;
#(
    parameter int LIMIT = DMEM_STARVE_LIMIT,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q >= LIM);

endmodule

// File: rtl/rvc_asap_dmem_arbiter.sv
// rtl/rvc_asap_dmem_arbiter.sv - core/external arbiter for the single D_MEM port
module rvc_asap_dmem_arbiter
    import rvc_asap_pkg::*;
#(
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT,
    parameter int CNT_W        = 8
) (
    input  logic        Clock,
    input  logic        RstN,
    input  logic [31:0] CoreAddr,
    input  logic [31:0] CoreWrData,
    input  logic [3:0]  CoreByteEn,
    input  logic        CoreWrEn,
    input  logic        CoreRdEn,
    output logic [31:0] CoreRdData,
    output logic        CoreStall,
    input  logic        ExtReq,
    input  logic        ExtWrEn,
    input  logic [31:0] ExtAddr,
    input  logic [31:0] ExtWrData,
    input  logic [3:0]  ExtByteEn,
    output logic        ExtGnt,
    output logic        ExtRdValid,
    output logic [31:0] ExtRdData,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemByteEn,
    output logic        MemWrEn,
    output logic        MemRdEn,
    input  logic [31:0] MemRdData
);

    t_dmem_owner owner;
    t_dmem_owner rd_owner_q;
    t_dmem_owner rd_owner_d;
    logic        core_acc;
    logic        at_limit;
    logic        force_ext;

    assign core_acc  = CoreWrEn | CoreRdEn;
    assign force_ext = ExtReq & at_limit;

    rvc_asap_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk      (Clock),
        .rst_n    (RstN),
        .clr      (ExtGnt),
        .inc      (ExtReq & ~ExtGnt),
        .at_limit (at_limit)
    );

    // Owner is gated by reset so no access leaks to D_MEM while RstN is low.
    always_comb begin
        owner     = OWN_NONE;
        CoreStall = 1'b0;
        if (!RstN) begin
            owner = OWN_NONE;
        end else if (force_ext) begin
            owner     = OWN_EXT;
            CoreStall = core_acc;
        end else if (core_acc) begin
            owner = OWN_CORE;
        end else if (ExtReq) begin
            owner = OWN_EXT;
        end
    end

    assign ExtGnt = (owner == OWN_EXT);

    always_comb begin
        MemAddr   = CoreAddr;
        MemWrData = CoreWrData;
        MemByteEn = CoreByteEn;
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        case (owner)
            OWN_CORE: begin
                MemWrEn = CoreWrEn;
                MemRdEn = CoreRdEn;
            end
            OWN_EXT: begin
                MemAddr   = ExtAddr;
                MemWrData = ExtWrData;
                MemByteEn = ExtByteEn;
                MemWrEn   = ExtWrEn;
                MemRdEn   = ~ExtWrEn;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge RstN) begin
        if (!RstN) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if ((owner == OWN_CORE) && CoreRdEn) begin
            rd_owner_d = OWN_CORE;
        end else if ((owner == OWN_EXT) && !ExtWrEn) begin
            rd_owner_d = OWN_EXT;
        end
    end

    always_comb begin
        ExtRdValid = (rd_owner_q == OWN_EXT);
        ExtRdData  = MemRdData;
        CoreRdData = (rd_owner_q == OWN_CORE) ? MemRdData : 32'h0;
    end

endmodule

// File: tb/tb_rvc_asap_dmem_arbiter.sv
// tb/tb_rvc_asap_dmem_arbiter.sv - self-checking bench with behavioural arbiter model
module tb_rvc_asap_dmem_arbiter;

    localparam int LIM = 4;

    logic        Clock = 1'b0;
    logic        RstN;
    logic [31:0] CoreAddr, CoreWrData, CoreRdData;
    logic [3:0]  CoreByteEn;
    logic        CoreWrEn, CoreRdEn, CoreStall;
    logic        ExtReq, ExtWrEn, ExtGnt, ExtRdValid;
    logic [31:0] ExtAddr, ExtWrData, ExtRdData;
    logic [3:0]  ExtByteEn;
    logic [31:0] MemAddr, MemWrData, MemRdData;
    logic [3:0]  MemByteEn;
    logic        MemWrEn, MemRdEn;

    int checks = 0;
    int failures = 0;

    int m_starve = 0;
    int m_pend = 0;
    bit hold_core = 0;
    bit hold_ext = 0;

    logic        obs_gnt, obs_stall, obs_erv, obs_mwe;
    logic [31:0] obs_erd, obs_crd;
    logic [3:0]  obs_mbe;

    always #5 Clock = ~Clock;

    rvc_asap_dmem_arbiter #(.STARVE_LIMIT(LIM), .CNT_W(8)) dut (
        .Clock      (Clock),
        .RstN       (RstN),
        .CoreAddr   (CoreAddr),
        .CoreWrData (CoreWrData),
        .CoreByteEn (CoreByteEn),
        .CoreWrEn   (CoreWrEn),
        .CoreRdEn   (CoreRdEn),
        .CoreRdData (CoreRdData),
        .CoreStall  (CoreStall),
        .ExtReq     (ExtReq),
        .ExtWrEn    (ExtWrEn),
        .ExtAddr    (ExtAddr),
        .ExtWrData  (ExtWrData),
        .ExtByteEn  (ExtByteEn),
        .ExtGnt     (ExtGnt),
        .ExtRdValid (ExtRdValid),
        .ExtRdData  (ExtRdData),
        .MemAddr    (MemAddr),
        .MemWrData  (MemWrData),
        .MemByteEn  (MemByteEn),
        .MemWrEn    (MemWrEn),
        .MemRdEn    (MemRdEn),
        .MemRdData  (MemRdData)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check at negedge against the model, then advance model at posedge.
    task automatic step();
        bit core_acc, exp_force, exp_win;
        @(negedge Clock);
        if (!RstN) begin
            m_starve = 0;
            m_pend   = 0;
        end
        core_acc  = CoreWrEn | CoreRdEn;
        exp_force = RstN && ExtReq && (m_starve >= LIM);
        exp_win   = RstN && ExtReq && (exp_force || !core_acc);
        check_eq("ext_gnt",    32'(ExtGnt),    32'(exp_win));
        check_eq("core_stall", 32'(CoreStall), 32'(exp_force && core_acc));
        check_eq("mem_wr_en",  32'(MemWrEn),   32'(RstN && (exp_win ? ExtWrEn : CoreWrEn)));
        check_eq("mem_rd_en",  32'(MemRdEn),   32'(RstN && (exp_win ? !ExtWrEn : CoreRdEn)));
        check_eq("mem_addr",   MemAddr,        exp_win ? ExtAddr : CoreAddr);
        check_eq("mem_wr_data", MemWrData,     exp_win ? ExtWrData : CoreWrData);
        check_eq("mem_byte_en", 32'(MemByteEn), 32'(exp_win ? ExtByteEn : CoreByteEn));
        check_eq("ext_rd_valid", 32'(ExtRdValid), 32'(m_pend == 2));
        if (m_pend == 2) check_eq("ext_rd_data", ExtRdData, MemRdData);
        check_eq("core_rd_data", CoreRdData, (m_pend == 1) ? MemRdData : 32'h0);
        obs_gnt = ExtGnt; obs_stall = CoreStall; obs_erv = ExtRdValid;
        obs_erd = ExtRdData; obs_crd = CoreRdData; obs_mwe = MemWrEn; obs_mbe = MemByteEn;
        @(posedge Clock);
        if (RstN) begin
            if (exp_win) m_starve = 0;
            else if (ExtReq && m_starve < 255) m_starve++;
            m_pend    = exp_win ? (ExtWrEn ? 0 : 2) : (CoreRdEn ? 1 : 0);
            hold_core = exp_force && core_acc;
            hold_ext  = ExtReq && !exp_win;
        end else begin
            hold_core = 0;
            hold_ext  = ExtReq;
        end
        #1;
    endtask

    task automatic rand_in();
        if (!hold_core) begin
            CoreRdEn   = 1'($urandom_range(0, 1));
            CoreWrEn   = !CoreRdEn && ($urandom_range(0, 3) == 0);
            CoreAddr   = $urandom;
            CoreWrData = $urandom;
            CoreByteEn = 4'($urandom);
        end
        if (!hold_ext) begin
            ExtReq    = ($urandom_range(0, 2) != 0);
            ExtWrEn   = 1'($urandom_range(0, 1));
            ExtAddr   = $urandom;
            ExtWrData = $urandom;
            ExtByteEn = 4'($urandom);
        end
        MemRdData = $urandom;
    endtask

    initial begin
        RstN = 1'b0;
        CoreAddr = 32'h100; CoreWrData = 32'h0; CoreByteEn = 4'hF;
        CoreWrEn = 1'b0; CoreRdEn = 1'b1;
        ExtReq = 1'b1; ExtWrEn = 1'b0; ExtAddr = 32'h0000_1000;
        ExtWrData = 32'h0; ExtByteEn = 4'hF; MemRdData = 32'h5555_AAAA;

        step();
        step();
        RstN = 1'b1;
        step();
        check_eq("post_rst_gnt", 32'(obs_gnt), 32'd0);

        CoreRdEn = 1'b0;
        step();
        check_eq("idle_ext_gnt", 32'(obs_gnt), 32'd1);
        ExtReq = 1'b0; MemRdData = 32'hDEAD_BEEF;
        step();
        check_eq("ext_rd_valid_c1", 32'(obs_erv), 32'd1);
        check_eq("ext_rd_word", obs_erd, 32'hDEAD_BEEF);
        check_eq("core_rd_zero", obs_crd, 32'h0);

        CoreRdEn = 1'b1; ExtReq = 1'b1; ExtWrEn = 1'b1; ExtAddr = 32'h0000_5000;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("starve_gnt", 32'(obs_gnt), 32'(i == 5));
            check_eq("starve_stall", 32'(obs_stall), 32'(i == 5));
        end
        ExtReq = 1'b0;
        step();
        check_eq("resume_stall", 32'(obs_stall), 32'd0);

        CoreRdEn = 1'b1; CoreAddr = 32'h0000_2000;
        step();
        CoreRdEn = 1'b0; ExtReq = 1'b1; ExtWrEn = 1'b0; ExtAddr = 32'h0000_3000;
        MemRdData = 32'hC0DE_0001;
        step();
        check_eq("core_rd_word", obs_crd, 32'hC0DE_0001);
        ExtReq = 1'b0; MemRdData = 32'hC0DE_0002;
        step();
        check_eq("ext_rd_word2", obs_erd, 32'hC0DE_0002);

        ExtReq = 1'b1; ExtWrEn = 1'b1; ExtAddr = 32'h0000_4000;
        ExtWrData = 32'h1234_5678; ExtByteEn = 4'b0011;
        step();
        check_eq("ext_wr_en", 32'(obs_mwe), 32'd1);
        check_eq("ext_wr_be", 32'(obs_mbe), 32'h3);
        ExtReq = 1'b0;
        step();
        check_eq("ext_wr_no_valid", 32'(obs_erv), 32'd0);

        ExtReq = 1'b1; ExtWrEn = 1'b0; ExtAddr = 32'h0000_6000;
        step();
        ExtReq = 1'b0; RstN = 1'b0;
        step();
        check_eq("rst_drop_valid", 32'(obs_erv), 32'd0);
        RstN = 1'b1;
        CoreRdEn = 1'b1; ExtReq = 1'b1; ExtWrEn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("rst_starve_gnt", 32'(obs_gnt), 32'(i == 5));
        end
        ExtReq = 1'b0;
        step();

        for (int n = 0; n < 400; n++) begin
            rand_in();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
